// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low patterns (bit6=g .. bit0=a),
// error codes and the bus monitor FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] ERR_PATTERN = 2'b01;
  localparam logic [1:0] ERR_STROBE  = 2'b10;

  typedef enum logic {WAIT, LOCKED} mon_state_t;

  // Forward encoding, used by the display encoder side of the loopback.
  function automatic logic [6:0] seg7_encode(input logic [3:0] v);
    case (v)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational decode of an active-low segment pattern back to hex.
// 'blank' is kept separate from 'legal' so the caller can clear a digit.
module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] val,
  output logic       legal,
  output logic       blank
);

  // Pattern lookup; anything not in the table is illegal.
  always_comb begin
    val   = 4'h0;
    legal = 1'b1;
    blank = 1'b0;
    case (seg)
      SEG_0: val = 4'h0;
      SEG_1: val = 4'h1;
      SEG_2: val = 4'h2;
      SEG_3: val = 4'h3;
      SEG_4: val = 4'h4;
      SEG_5: val = 4'h5;
      SEG_6: val = 4'h6;
      SEG_7: val = 4'h7;
      SEG_8: val = 4'h8;
      SEG_9: val = 4'h9;
      SEG_A: val = 4'hA;
      SEG_B: val = 4'hB;
      SEG_C: val = 4'hC;
      SEG_D: val = 4'hD;
      SEG_E: val = 4'hE;
      SEG_F: val = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_bus_monitor.sv
// Receive-side monitor for the multiplexed seven-segment bus. A pattern is
// accepted once {seg, an} has been stable for STABLE_CYCLES samples, then
// decoded into one value register per digit. All outputs are registered.
module seg7_bus_monitor
  import seg7_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [6:0]          seg,
  input  logic [NDIG-1:0]     an,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     digit_valid,
  output logic                upd,
  output logic [2:0]          upd_idx,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam int             CW      = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_ACC = CW'(STABLE_CYCLES - 1);

  logic [6:0]      seg_q;
  logic [NDIG-1:0] an_q;
  logic [CW-1:0]   cnt;
  mon_state_t      state;

  logic            match;
  logic [3:0]      nlow;
  logic [2:0]      idx;
  logic [3:0]      dec_val;
  logic            dec_legal;
  logic            dec_blank;
  logic            accept;
  logic            acc_one;

  seg7_pattern_dec u_dec (
    .seg   (seg_q),
    .val   (dec_val),
    .legal (dec_legal),
    .blank (dec_blank)
  );

  assign match   = (seg == seg_q) && (an == an_q);
  assign accept  = match && (state == WAIT) && (cnt == CNT_ACC);
  assign acc_one = accept && (nlow == 4'd1);

  // Count low strobes and locate the driven digit (valid only when one is low).
  always_comb begin
    nlow = 4'd0;
    idx  = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_q[i]) begin
        nlow = nlow + 4'd1;
        idx  = 3'(i);
      end
    end
  end

  // Input sampling, stability counter, accept FSM and event pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
      cnt      <= '0;
      state    <= WAIT;
      upd      <= 1'b0;
      upd_idx  <= 3'd0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      seg_q <= seg;
      an_q  <= an;
      upd   <= 1'b0;
      err   <= 1'b0;
      if (!match) begin
        cnt   <= '0;
        state <= WAIT;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (accept) begin
          state <= LOCKED;
          if (nlow > 4'd1) begin
            err      <= 1'b1;
            err_code <= ERR_STROBE;
          end else if (nlow == 4'd1) begin
            if (dec_legal || dec_blank) begin
              upd     <= 1'b1;
              upd_idx <= idx;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_PATTERN;
            end
          end
        end
      end
    end
  end

  // Per-digit value/valid registers, written only by a single-strobe accept.
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    logic [3:0] d;
    logic       v;

    // Legal pattern loads the value, blank clears it, illegal only drops valid.
    always_ff @(posedge clock) begin
      if (reset) begin
        d <= 4'h0;
        v <= 1'b0;
      end else if (acc_one && (idx == 3'(i))) begin
        if (dec_legal) begin
          d <= dec_val;
          v <= 1'b1;
        end else if (dec_blank) begin
          d <= 4'h0;
          v <= 1'b0;
        end else begin
          v <= 1'b0;
        end
      end
    end

    assign digits[4*i +: 4] = d;
    assign digit_valid[i]   = v;
  end

endmodule

// File: tb/tb_seg7_bus_monitor.sv
// Directed bench for seg7_bus_monitor: expected upd/err events (with the
// cycle they must appear in) are queued when stimulus is driven and popped
// by a monitor whenever the DUT pulses.
module tb_seg7_bus_monitor;

  localparam int NDIG = 4;
  localparam int S    = 4;

  localparam logic [6:0] P2  = 7'b0100100;
  localparam logic [6:0] P3  = 7'b0110000;
  localparam logic [6:0] P5  = 7'b0010010;
  localparam logic [6:0] P8  = 7'b0000000;
  localparam logic [6:0] PA  = 7'b0001000;
  localparam logic [6:0] PF  = 7'b0001110;
  localparam logic [6:0] BL  = 7'h7F;
  localparam logic [6:0] BAD = 7'b1010101;

  localparam logic [1:0] K_UPD = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [2:0] idx;
    logic [1:0] code;
    int         cyc;
  } exp_t;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [6:0]          seg   = 7'h7F;
  logic [NDIG-1:0]     an    = '1;
  logic [4*NDIG-1:0]   digits;
  logic [NDIG-1:0]     digit_valid;
  logic                upd;
  logic [2:0]          upd_idx;
  logic                err;
  logic [1:0]          err_code;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   base  = 0;
  exp_t sb[$];

  seg7_bus_monitor #(.NDIG(NDIG), .STABLE_CYCLES(S)) dut (
    .clock       (clock),
    .reset       (reset),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .digit_valid (digit_valid),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [2:0] idx, input logic [1:0] code);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.code = code;
    e.cyc  = base + 1 + S;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [6:0] s, input logic [NDIG-1:0] a);
    @(negedge clock);
    seg  = s;
    an   = a;
    base = cyc;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Every pulse must match the oldest pending expectation, including its cycle.
  always @(posedge clock) begin
    #1;
    if (upd || err) begin
      exp_t e;
      if (sb.size() > 0) e = sb.pop_front();
      else begin
        e.kind = 2'd0; e.idx = 3'd0; e.code = 2'd0; e.cyc = 0;
      end
      check("evt_kind", 32'({err, upd}), 32'(e.kind));
      if (e.kind != 2'd0) check("evt_cycle", 32'(cyc), 32'(e.cyc));
      if (upd && e.kind == K_UPD) check("upd_idx", 32'(upd_idx), 32'(e.idx));
      if (err && e.kind == K_ERR) check("err_code", 32'(err_code), 32'(e.code));
    end
  end

  initial begin
    // Reset state
    hold(3);
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_upd", 32'(upd), 32'h0);
    check("rst_upd_idx", 32'(upd_idx), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_err_code", 32'(err_code), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    hold(3);

    // First accept: digit 0 = 3, timing checked through the queue
    drive(P3, 4'b1110); push(K_UPD, 3'd0, 2'd0);
    hold(S);
    check("no_early_upd", 32'(sb.size()), 32'd1);
    hold(6);
    check("first_digits", 32'(digits), 32'h0003);
    check("first_valid", 32'(digit_valid), 32'b0001);

    // Scan 2, A, F, blank over digits 0..3
    drive(P2, 4'b1110); push(K_UPD, 3'd0, 2'd0); hold(6);
    drive(PA, 4'b1101); push(K_UPD, 3'd1, 2'd0); hold(6);
    drive(PF, 4'b1011); push(K_UPD, 3'd2, 2'd0); hold(6);
    drive(BL, 4'b0111); push(K_UPD, 3'd3, 2'd0); hold(6);
    check("scan_digits", 32'(digits), 32'h0FA2);
    check("scan_valid", 32'(digit_valid), 32'b0111);

    // Digit 0 back to 3, then a 2-cycle glitch to 8 and return to 3
    drive(P3, 4'b1110); push(K_UPD, 3'd0, 2'd0); hold(6);
    check("d0_three", 32'(digits), 32'h0FA3);
    drive(P8, 4'b1110);
    repeat (2) @(posedge clock);
    drive(P3, 4'b1110); push(K_UPD, 3'd0, 2'd0); hold(6);
    check("glitch_digits", 32'(digits), 32'h0FA3);
    check("glitch_valid", 32'(digit_valid), 32'b0111);

    // Two strobes low: strobe conflict, registers untouched
    drive(P3, 4'b1100); push(K_ERR, 3'd0, 2'b10); hold(6);
    check("strobe_digits", 32'(digits), 32'h0FA3);
    check("strobe_valid", 32'(digit_valid), 32'b0111);

    // Illegal pattern on digit 1: valid drops, value kept
    drive(BAD, 4'b1101); push(K_ERR, 3'd0, 2'b01); hold(6);
    check("badpat_digits", 32'(digits), 32'h0FA3);
    check("badpat_valid", 32'(digit_valid), 32'b0101);

    // Reset mid-count clears everything; full count needed afterwards
    drive(P5, 4'b1011);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    hold(1);
    check("midrst_digits", 32'(digits), 32'h0);
    check("midrst_valid", 32'(digit_valid), 32'h0);
    check("midrst_upd", 32'(upd), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    base  = cyc;
    push(K_UPD, 3'd2, 2'd0);
    hold(8);
    check("post_rst_digits", 32'(digits), 32'h0500);
    check("post_rst_valid", 32'(digit_valid), 32'b0100);

    // Reset while locked
    @(negedge clock);
    reset = 1'b1;
    hold(1);
    check("lockrst_digits", 32'(digits), 32'h0);
    check("lockrst_valid", 32'(digit_valid), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    seg   = BL;
    an    = '1;
    hold(8);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
